// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle control sequencer: control-word
// field layout, instruction-class codes, FSM encoding and opcode masks.
package cpu_ctrl_pkg;

  localparam int CW_WIDTH    = 29;
  localparam int COUNT_WIDTH = 16;

  // Control word fields
  localparam int PSEL_HI  = 28;
  localparam int PSEL_LO  = 27;
  localparam int DA_HI    = 26;
  localparam int DA_LO    = 22;
  localparam int SA_HI    = 21;
  localparam int SA_LO    = 17;
  localparam int SB_HI    = 16;
  localparam int SB_LO    = 12;
  localparam int FSEL_HI  = 11;
  localparam int FSEL_LO  = 7;
  localparam int REGW_BIT = 6;
  localparam int RAMW_BIT = 5;
  localparam int DSEL_HI  = 4;
  localparam int DSEL_LO  = 3;
  localparam int BSEL_BIT = 2;
  localparam int PCSEL_BIT = 1;
  localparam int SL_BIT   = 0;

  // Clears Psel, regW, ramW and SL so a stalled memory access neither
  // advances the PC nor commits any write.
  localparam logic [CW_WIDTH-1:0] CW_STALL_MASK = ~((29'd3 << PSEL_LO) |
                                                    (29'd1 << REGW_BIT) |
                                                    (29'd1 << RAMW_BIT) |
                                                    (29'd1 << SL_BIT));

  // Instruction classes
  localparam logic [2:0] ICLASS_NONE    = 3'd0;
  localparam logic [2:0] ICLASS_R       = 3'd1;
  localparam logic [2:0] ICLASS_I       = 3'd2;
  localparam logic [2:0] ICLASS_D       = 3'd3;
  localparam logic [2:0] ICLASS_B       = 3'd4;
  localparam logic [2:0] ICLASS_ILLEGAL = 3'd7;

  // Major FSM states
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Opcode class match: (instruction & MASK) == MATCH
  localparam logic [31:0] D_MASK  = 32'h0A00_0000;  // bits 27,25
  localparam logic [31:0] D_MATCH = 32'h0800_0000;
  localparam logic [31:0] R_MASK  = 32'h0E00_0000;  // bits 27:25
  localparam logic [31:0] R_MATCH = 32'h0A00_0000;
  localparam logic [31:0] I_MASK  = 32'h1C00_0000;  // bits 28:26
  localparam logic [31:0] I_MATCH = 32'h1000_0000;
  localparam logic [31:0] B_MASK  = 32'h1C00_0000;
  localparam logic [31:0] B_MATCH = 32'h1400_0000;

endpackage

// File: rtl/control_sequencer_opclass_decode.sv
// Pure combinational instruction-class decoder; first match wins.
module opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [2:0]  iclass
);

  // Priority classification of the raw instruction word
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    iclass = ICLASS_ILLEGAL;
    if ((instruction & D_MASK) == D_MATCH)      iclass = ICLASS_D;
    else if ((instruction & R_MASK) == R_MATCH) iclass = ICLASS_R;
    else if ((instruction & I_MASK) == I_MATCH) iclass = ICLASS_I;
    else if ((instruction & B_MASK) == B_MATCH) iclass = ICLASS_B;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: latches an instruction, steps the per-class
// decoders through their sub-states, stalls on data memory and halts on
// illegal opcodes or a decoder that loops on its own state.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W    = CW_WIDTH,
  parameter int COUNT_W = COUNT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic [CW_W-1:0]    cw_r,
  input  logic [CW_W-1:0]    cw_i,
  input  logic [CW_W-1:0]    cw_d,
  input  logic [CW_W-1:0]    cw_b,
  input  logic [1:0]         ns_r,
  input  logic [1:0]         ns_i,
  input  logic [1:0]         ns_d,
  input  logic [1:0]         ns_b,
  output logic [31:0]        ir,
  output logic [1:0]         state,
  output logic [CW_W-1:0]    controlWord,
  output logic [2:0]         iclass,
  output logic               fetch_req,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  logic [1:0]      fsm;
  logic [2:0]      dec_class;
  logic [CW_W-1:0] cw_sel;
  logic [1:0]      ns_sel;
  logic            stall;

  opclass_decode u_decode (
    .instruction (instruction),
    .iclass      (dec_class)
  );

  // Select the active decoder's control word and next sub-state
  always_comb begin
    cw_sel = '0;
    ns_sel = 2'd0;
    case (iclass)
      ICLASS_R: begin cw_sel = cw_r; ns_sel = ns_r; end
      ICLASS_I: begin cw_sel = cw_i; ns_sel = ns_i; end
      ICLASS_D: begin cw_sel = cw_d; ns_sel = ns_d; end
      ICLASS_B: begin cw_sel = cw_b; ns_sel = ns_b; end
      default:  begin cw_sel = '0;   ns_sel = 2'd0; end
    endcase
  end

  assign stall = (fsm == ST_EXEC) && (iclass == ICLASS_D) && !mem_ready;

  // Write enables only reach the datapath in EXEC, masked while stalled
  always_comb begin
    controlWord = '0;
    if (fsm == ST_EXEC)
      controlWord = stall ? (cw_sel & CW_W'(CW_STALL_MASK)) : cw_sel;
  end

  // Major FSM, instruction register, sub-step and retire counter
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      fsm       <= ST_FETCH;
      ir        <= '0;
      state     <= 2'd0;
      iclass    <= ICLASS_NONE;
      fetch_req <= 1'b0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      case (fsm)
        ST_FETCH: begin
          if (instr_valid) begin
            ir        <= instruction;
            state     <= 2'd0;
            iclass    <= dec_class;
            fetch_req <= 1'b0;
            if (dec_class == ICLASS_ILLEGAL) begin
              fsm    <= ST_HALT;
              halted <= 1'b1;
            end else begin
              fsm <= ST_EXEC;
            end
          end else begin
            fetch_req <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (ns_sel == 2'd0) begin
              retired   <= retired + 1'b1;
              state     <= 2'd0;
              fsm       <= ST_FETCH;
              fetch_req <= 1'b1;
            end else if (ns_sel == state) begin
              fsm    <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state <= ns_sel;
            end
          end
        end
        ST_HALT: begin
          halted    <= 1'b1;
          fetch_req <= 1'b0;
        end
        default: begin
          fsm       <= ST_HALT;
          halted    <= 1'b1;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_ready;
  logic [28:0] cw_r, cw_i, cw_d, cw_b;
  logic [1:0]  ns_r, ns_i, ns_d, ns_b;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [28:0] controlWord;
  logic [2:0]  iclass;
  logic        fetch_req;
  logic        halted;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .cw_r        (cw_r),
    .cw_i        (cw_i),
    .cw_d        (cw_d),
    .cw_b        (cw_b),
    .ns_r        (ns_r),
    .ns_i        (ns_i),
    .ns_d        (ns_d),
    .ns_b        (ns_b),
    .ir          (ir),
    .state       (state),
    .controlWord (controlWord),
    .iclass      (iclass),
    .fetch_req   (fetch_req),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ir"},        ir, 32'h0);
    check({tag, " state"},     32'(state), 32'h0);
    check({tag, " iclass"},    32'(iclass), 32'h0);
    check({tag, " cw"},        32'(controlWord), 32'h0);
    check({tag, " fetch_req"}, 32'(fetch_req), 32'h0);
    check({tag, " halted"},    32'(halted), 32'h0);
    check({tag, " retired"},   32'(retired), 32'h0);
  endtask

  initial begin
    reset = 1'b0; instruction = '0; instr_valid = 1'b0; mem_ready = 1'b0;
    cw_r = '0; cw_i = '0; cw_d = '0; cw_b = '0;
    ns_r = '0; ns_i = '0; ns_d = '0; ns_b = '0;
    #3;
    check_reset_values("por");
    #9 reset = 1'b1;
    step();
    check("idle fetch_req", 32'(fetch_req), 32'h1);

    // R-class single step
    instruction = 32'h8B02_0020; instr_valid = 1'b1;
    cw_r = 29'h0A5_A5A5; ns_r = 2'd0;
    step();
    instr_valid = 1'b0;
    check("r iclass", 32'(iclass), 32'h1);
    check("r ir", ir, 32'h8B02_0020);
    check("r cw", 32'(controlWord), 32'h00A5_A5A5);
    check("r fetch_req", 32'(fetch_req), 32'h0);
    step();
    check("r done fetch_req", 32'(fetch_req), 32'h1);
    check("r done retired", 32'(retired), 32'h1);
    check("r done cw", 32'(controlWord), 32'h0);

    // D-class with three stall cycles
    instruction = 32'hF840_0020; instr_valid = 1'b1;
    cw_d = 29'h1FFF_FFFF; ns_d = 2'd0; mem_ready = 1'b0;
    step();
    instr_valid = 1'b0;
    check("d iclass", 32'(iclass), 32'h3);
    for (int i = 0; i < 3; i++) begin
      check("d stall cw", 32'(controlWord), 32'h07FF_FF9E);
      check("d stall state", 32'(state), 32'h0);
      if (i < 2) step();
    end
    mem_ready = 1'b1;
    #1 check("d ready cw", 32'(controlWord), 32'h1FFF_FFFF);
    step();
    mem_ready = 1'b0;
    check("d retired", 32'(retired), 32'h2);
    check("d fetch_req", 32'(fetch_req), 32'h1);

    // B-class two steps
    instruction = 32'h1400_0004; instr_valid = 1'b1;
    cw_b = 29'h123_4567; ns_b = 2'd1;
    step();
    instr_valid = 1'b0;
    check("b iclass", 32'(iclass), 32'h4);
    check("b state0", 32'(state), 32'h0);
    check("b cw", 32'(controlWord), 32'h0123_4567);
    step();
    ns_b = 2'd0;
    check("b state1", 32'(state), 32'h1);
    check("b exec fetch_req", 32'(fetch_req), 32'h0);
    step();
    check("b retired", 32'(retired), 32'h3);
    check("b fetch_req", 32'(fetch_req), 32'h1);

    // Async reset in the middle of a D stall
    instruction = 32'hF840_0020; instr_valid = 1'b1; mem_ready = 1'b0;
    step();
    instr_valid = 1'b0;
    check("mid stall cw", 32'(controlWord), 32'h07FF_FF9E);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    #3 reset = 1'b1;
    step();
    check("post reset fetch_req", 32'(fetch_req), 32'h1);

    // Loop guard: ns_r stuck at 2
    instruction = 32'h8B02_0020; instr_valid = 1'b1; ns_r = 2'd2;
    step();
    instr_valid = 1'b0;
    step();
    check("loop state2", 32'(state), 32'h2);
    check("loop not halted", 32'(halted), 32'h0);
    step();
    check("loop halted", 32'(halted), 32'h1);
    check("loop cw", 32'(controlWord), 32'h0);
    check("loop retired", 32'(retired), 32'h0);

    // Illegal opcode halts; later fetches ignored
    reset = 1'b0;
    #2 reset = 1'b1;
    ns_r = 2'd0;
    instruction = 32'h0000_0000; instr_valid = 1'b1;
    step();
    check("ill halted", 32'(halted), 32'h1);
    check("ill iclass", 32'(iclass), 32'h7);
    check("ill cw", 32'(controlWord), 32'h0);
    check("ill fetch_req", 32'(fetch_req), 32'h0);
    instruction = 32'h8B02_0020;
    step();
    step();
    instr_valid = 1'b0;
    check("ill stay halted", 32'(halted), 32'h1);
    check("ill ir held", ir, 32'h0);
    check("ill iclass held", 32'(iclass), 32'h7);
    check("ill retired", 32'(retired), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit for the single-datapath CPU.
- Latches each fetched instruction and classifies it as R-ALU, I-ALU, D-mem, branch or illegal.
- Drives the 2-bit sub-step `state` into the per-class decoders and forwards the selected 29-bit control word to the datapath.
- Stalls on data-memory handshakes, masks all write enables outside execution, and halts on illegal opcodes.

Parameters:
- CW_WIDTH, 29, control word width: {Psel[28:27], DA[26:22], SA[21:17], SB[16:12], Fsel[11:7], regW[6], ramW[5], Dsel[4:3], Bsel[2], PCsel[1], SL[0]}.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  32  fetched instruction word.
- instr_valid  in  1  instruction memory has a valid word this cycle.
- mem_ready  in  1  data memory access completes this cycle.
- cw_r, cw_i, cw_d, cw_b  in  CW_WIDTH each  control words from the R/I/D/B decoders for the current `state`.
- ns_r, ns_i, ns_d, ns_b  in  2 each  nextState outputs from those decoders.
- ir  out  32  latched instruction register, which feeds the decoders.
- state  out  2  current sub-step, which feeds the decoders.
- controlWord  out  CW_WIDTH  control word to the datapath.
- iclass  out  3  0=NONE, 1=R, 2=I, 3=D, 4=B, 7=ILLEGAL.
- fetch_req  out  1  requests the next instruction.
- halted  out  1  set in HALT.
- retired  out  COUNT_WIDTH  count of completed instructions.

Behaviour:
- Reset (async, reset=0) values:
  - FSM in FETCH; ir=0, state=0, iclass=NONE.
  - controlWord=0, fetch_req=0, halted=0, retired=0.
  - All outputs are registered except controlWord, which is combinational from registered state.
- Major states: FETCH, EXEC, HALT.
- FETCH:
  - fetch_req=1 and controlWord=0.
  - When instr_valid=1: ir<=instruction, state<=0, iclass<=decode(instruction), then go to EXEC. If the decode is ILLEGAL, go to HALT instead.
  - When instr_valid=0: hold in FETCH.
- Classification is evaluated on `instruction` at latch time, first match wins:
  - D if instruction[27]=1 and instruction[25]=0.
  - R if instruction[27:25]=3'b101.
  - I if instruction[28:26]=3'b100.
  - B if instruction[28:26]=3'b101.
  - Otherwise ILLEGAL.
- EXEC:
  - fetch_req=0. controlWord = cw_<iclass>, and ns = ns_<iclass>.
  - D-class stall: when iclass=D and mem_ready=0, hold `state` and mask controlWord bits Psel, regW, ramW and SL to 0; the other fields pass through.
  - Otherwise, on the clock edge:
    - If ns≠0: state<=ns and stay in EXEC.
    - If ns=0: retired<=retired+1 (wraps at 2^COUNT_WIDTH), state<=0, go to FETCH.
  - Loop guard: if ns equals the current state while ns≠0, go to HALT and do not count the instruction.
- HALT:
  - halted=1, controlWord=0 (Psel=00 holds PC), fetch_req=0.
  - Exited only by reset.
- Reset asserted mid-EXEC or mid-stall returns every output to its reset value immediately (asynchronous). No partial write enables may persist.
- Single-cycle latency: an instruction latched at edge N drives its first controlWord during cycle N+1. A 1-step instruction occupies 1 FETCH cycle plus 1 EXEC cycle.
- instr_valid is ignored outside FETCH. mem_ready is ignored unless the FSM is in EXEC with iclass=D.

Decomposition:
- Shared package (cpu_ctrl_pkg) holds:
  - CW field bit positions and a stall mask constant.
  - iclass encodings.
  - FSM state encoding.
  - Opcode-class match masks.
- One natural sub-module: opclass_decode (pure combinational instruction→iclass), reusable by the fetch stage.

Test Plan:
- Reset, then instr_valid=1 with 0x8B020020 (ADD, bits[27:25]=101), ns_r=0, cw_r=0x0A5A5A5:
  - Next cycle: iclass=1 and controlWord=0x0A5A5A5.
  - Following cycle: FETCH with fetch_req=1 and retired=1.
- D-class instruction 0xF8400020, ns_d=0, mem_ready=0 for 3 cycles then 1:
  - Stall cycles: controlWord equals cw_d with bits 28:27, 6, 5 and 0 cleared.
  - On mem_ready=1: retired increments and the FSM returns to FETCH.
- Two-step B-class instruction 0x14000004 with ns_b=1 at state 0 and ns_b=0 at state 1:
  - `state` sequences 0→1.
  - Two EXEC cycles, then FETCH.
- Illegal word 0x00000000:
  - Goes straight to HALT: halted=1, controlWord=0.
  - Further instr_valid pulses are ignored until reset.
- Loop guard: ns_r=2 held at state=2 → HALT.
- Drive reset low mid-stall: all outputs return to their reset values asynchronously, before the next clock edge.
